// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, keyboard command constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_ACK       = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchroniser for PS/2 clock/data with registered clock falling-edge strobe
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_s1;
    logic data_s1;

    // Idle bus level is high, so the flops reset to 1 to avoid a spurious edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1    <= 1'b1;
            clk_sync  <= 1'b1;
            data_s1   <= 1'b1;
            data_sync <= 1'b1;
            clk_fall  <= 1'b0;
        end else begin
            clk_s1    <= clk_in;
            clk_sync  <= clk_s1;
            data_s1   <= data_in;
            data_sync <= data_s1;
            clk_fall  <= clk_sync & ~clk_s1;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain pull-low enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_clk_in,
    input  logic       PS2_data_in,
    output logic       PS2_clk_oe,
    output logic       PS2_data_oe,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    // The REQ cycle is the last inhibit cycle, so the clock is held low INHIBIT_CYCLES in total
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;
    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;

    ps2_line_sync u_sync (
        .clk       (system_clk),
        .rst_n     (reset),
        .clk_in    (PS2_clk_in),
        .data_in   (PS2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    assign busy = ~tx_ready;

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            tx_ready    <= 1'b1;
            PS2_clk_oe  <= 1'b0;
            PS2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    PS2_clk_oe  <= 1'b0;
                    PS2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg      <= {odd_parity(tx_data), tx_data};
                        cnt        <= '0;
                        PS2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= ST_INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        PS2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    PS2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    bit_idx    <= '0;
                    state      <= ST_SHIFT;
                end
                default: begin
                    if (cnt == TO_LAST) begin
                        PS2_clk_oe  <= 1'b0;
                        PS2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        case (state)
                            ST_SHIFT: begin
                                // shreg shifts out data then parity; the 10th edge releases data as stop
                                if (clk_fall) begin
                                    bit_idx <= bit_idx + 4'd1;
                                    if (bit_idx == 4'd9) begin
                                        PS2_data_oe <= 1'b0;
                                        state       <= ST_ACK;
                                    end else begin
                                        PS2_data_oe <= ~shreg[0];
                                        shreg       <= {1'b1, shreg[8:1]};
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    if (!data_sync) begin
                                        state <= ST_WAIT_IDLE;
                                    end else begin
                                        tx_err <= 1'b1;
                                        state  <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_sync && data_sync) begin
                                    tx_done <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench with PS/2 device model and expected-frame scoreboard for ps2_host_tx
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, clk_oe, data_oe, tx_done, tx_err, busy;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    always #5 clk = ~clk;

    assign clk_line  = ~(clk_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
        .system_clk  (clk),
        .reset       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .PS2_clk_in  (clk_line),
        .PS2_data_in (data_line),
        .PS2_clk_oe  (clk_oe),
        .PS2_data_oe (data_oe),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         total_pulses = 0;
    int         both_seen = 0;
    logic [9:0] exp_q[$];
    int         pulse_q[$];
    logic       ready_q[$];
    logic       prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (prev_pulse) ready_q.push_back(tx_ready);
        prev_pulse <= tx_done | tx_err;
        if (tx_done | tx_err) total_pulses <= total_pulses + 1;
        if (tx_done & tx_err) both_seen <= both_seen + 1;
        if (tx_done & ~tx_err) pulse_q.push_back(1);
        else if (tx_err & ~tx_done) pulse_q.push_back(2);
        else if (tx_err & tx_done) pulse_q.push_back(3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_of(input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(b[i]);
        return (n % 2 == 0);
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, par_of(b), b});
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: waits for the request, clocks 10 bits (sampling while clock is low->high), then ACK
    task automatic run_frame(input bit ack, input int abort_at, output int inh_len,
                             output logic [9:0] word, output logic start_bit);
        int guard = 0;
        inh_len   = 0;
        word      = '0;
        while (!clk_oe && guard < 100) begin @(negedge clk); guard++; end
        while (clk_oe && guard < 300) begin inh_len++; @(negedge clk); guard++; end
        start_bit = data_line;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i == abort_at) begin
                dev_clk_low = 1'b0;
                return;
            end
            word[i-1]   = data_line;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int bound, output int kind, output logic rdy);
        int guard = 0;
        while (ready_q.size() == 0 && guard < bound) begin @(negedge clk); guard++; end
        if (ready_q.size() == 0 || pulse_q.size() == 0) begin
            kind = 0;
            rdy  = 1'bx;
        end else begin
            kind = pulse_q.pop_front();
            rdy  = ready_q.pop_front();
        end
    endtask

    task automatic frame_ok(input string tag, input logic exp_par, input bit chk_inh);
        int         inh, kind;
        logic [9:0] word, exp;
        logic       sb, rdy;
        run_frame(1'b1, 0, inh, word, sb);
        exp = exp_q.pop_front();
        if (chk_inh) check({tag, "_inhibit_len"}, inh, INH);
        check({tag, "_start"}, sb, 1'b0);
        check({tag, "_frame"}, word, exp);
        check({tag, "_parity"}, word[8], exp_par);
        wait_pulse(200, kind, rdy);
        check({tag, "_done"}, kind, 1);
        check({tag, "_ready_after"}, rdy, 1'b1);
    endtask

    initial begin
        int         inh, kind, lat, guard;
        logic [9:0] word;
        logic [9:0] dropped;
        logic       sb, rdy;

        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         inh, kind, lat, guard;
        logic [9:0] word;
        logic [9:0] dropped;
        logic       sb, rdy;

        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_clk_oe", clk_oe, 1'b0);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_pulses", {tx_done, tx_err}, 2'b00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'hED);
        frame_ok("led_cmd", 1'b1, 1'b1);
        send(8'h01);
        frame_ok("byte01", 1'b0, 1'b1);
        send(8'h00);
        frame_ok("byte00", 1'b1, 1'b1);

        // Withheld ACK
        send(8'h55);
        run_frame(1'b0, 0, inh, word, sb);
        check("nack_frame", word, exp_q.pop_front());
        wait_pulse(200, kind, rdy);
        check("nack_err", kind, 2);
        check("nack_ready_next", rdy, 1'b1);

        // Device silent after request
        send(8'hA5);
        dropped = exp_q.pop_front();
        guard = 0;
        while (clk_oe && guard < 200) begin @(negedge clk); guard++; end
        lat = 0;
        while (pulse_q.size() == 0 && lat < 3000) begin @(negedge clk); lat++; end
        check("timeout_latency_ok", (lat >= TO - 5 && lat <= TO + 5), 1'b1);
        check("timeout_clk_oe", clk_oe, 1'b0);
        check("timeout_data_oe", data_oe, 1'b0);
        wait_pulse(200, kind, rdy);
        check("timeout_err", kind, 2);

        // Reset in the middle of the data bits
        send(8'h00);
        dropped = exp_q.pop_front();
        run_frame(1'b1, 4, inh, word, sb);
        check("abort_data_driven", data_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_clk_oe", clk_oe, 1'b0);
        check("abort_data_oe", data_oe, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", pulse_q.size(), 0);
        send(8'hFF);
        frame_ok("reset_cmd", 1'b1, 1'b1);

        // tx_valid held while busy with changing data
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, par_of(8'h12), 8'h12});
        @(negedge clk);
        check("hold_ready_low", tx_ready, 1'b0);
        check("hold_busy", busy, 1'b1);
        tx_data = 8'h34;
        exp_q.push_back({1'b1, par_of(8'h34), 8'h34});
        frame_ok("hold_first", 1'b1, 1'b0);
        guard = 0;
        while (!clk_oe && guard < 50) begin @(negedge clk); guard++; end
        check("hold_second_started", clk_oe, 1'b1);
        tx_valid = 1'b0;
        frame_ok("hold_second", 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("total_pulses", total_pulses, 8);
        check("never_both", both_seen, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
